// File: rtl/vm_credit_change_ctrl.sv
// -----------------------------------------------------------------------------
// vm_credit_change_ctrl
//
// Holds all of the vending machine's credit state. Inserted coins add to the
// credit register, and one affordable selected item is vended per cycle. An
// inactivity timer runs while credit is held. On timeout, or on a user
// return request, change is paid out one coin per cycle, largest coin first.
//
// States: IDLE (credit == 0), CREDIT (credit > 0), RETURN (paying change).
//
// Ports
//   clk              in   1           rising-edge clock
//   reset_n          in   1           asynchronous active-low reset
//   i_input_coin     in   NUM_COINS   one bit per denomination, 1-cycle pulse
//   i_select_item    in   NUM_ITEMS   item request, 1-cycle pulse
//   i_trigger_return in   1           user return request, 1-cycle pulse
//   o_available_item out  NUM_ITEMS   item affordable and block accepting (comb)
//   o_output_item    out  NUM_ITEMS   registered one-hot vend pulse
//   o_return_coin    out  NUM_COINS   registered one-hot change pulse
//   o_coin_reject    out  1           registered pulse: whole insertion refused
//   o_credit         out  TOTAL_BITS  current credit
//   o_wait_time      out  32          remaining inactivity count
//   o_returning      out  1           high while paying out change
// -----------------------------------------------------------------------------
module vm_credit_change_ctrl #(
  parameter int NUM_COINS  = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int TOTAL_BITS = 31,
  parameter int WAIT_TIME  = 100,
  // Index 0 occupies the least significant slice.
  parameter logic [NUM_COINS*TOTAL_BITS-1:0] COIN_VALUE = {31'd1000, 31'd500, 31'd100},
  parameter logic [NUM_ITEMS*TOTAL_BITS-1:0] ITEM_PRICE = {31'd2000, 31'd1000, 31'd500, 31'd400},
  parameter logic [TOTAL_BITS-1:0]           MAX_CREDIT = 31'd10000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_COINS-1:0]  i_input_coin,
  input  logic [NUM_ITEMS-1:0]  i_select_item,
  input  logic                  i_trigger_return,
  output logic [NUM_ITEMS-1:0]  o_available_item,
  output logic [NUM_ITEMS-1:0]  o_output_item,
  output logic [NUM_COINS-1:0]  o_return_coin,
  output logic                  o_coin_reject,
  output logic [TOTAL_BITS-1:0] o_credit,
  output logic [31:0]           o_wait_time,
  output logic                  o_returning
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CREDIT = 2'd1;
  localparam logic [1:0] ST_RETURN = 2'd2;

  // Coin sum is widened so several large coins in one cycle cannot wrap
  // before the ceiling comparison.
  localparam int SUM_W = TOTAL_BITS + $clog2(NUM_COINS + 1);

  localparam logic [31:0] WAIT_RELOAD = 32'(WAIT_TIME);

  function automatic logic [TOTAL_BITS-1:0] coin_val(input int j);
    return COIN_VALUE[j*TOTAL_BITS +: TOTAL_BITS];
  endfunction

  function automatic logic [TOTAL_BITS-1:0] item_price(input int i);
    return ITEM_PRICE[i*TOTAL_BITS +: TOTAL_BITS];
  endfunction

  logic [1:0]            state_q,  state_d;
  logic [TOTAL_BITS-1:0] credit_q, credit_d;
  logic [31:0]           timer_q,  timer_d;
  logic [NUM_ITEMS-1:0]  item_q,   item_d;
  logic [NUM_COINS-1:0]  ret_q,    ret_d;
  logic                  reject_q, reject_d;

  logic [SUM_W-1:0]      coin_sum;
  logic [SUM_W-1:0]      credit_ext;
  logic [TOTAL_BITS-1:0] after_vend;
  logic [TOTAL_BITS-1:0] credit_next;
  logic                  coin_ok;
  logic                  coin_acc;

  logic                  vend_hit;
  logic [NUM_ITEMS-1:0]  vend_oh;
  logic [TOTAL_BITS-1:0] vend_price;

  logic                  ret_hit;
  logic [NUM_COINS-1:0]  ret_oh;
  logic [TOTAL_BITS-1:0] ret_val;

  // Affordability, vend pick and change pick all look at registered credit.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default before any
    // conditional logic, so no path leaves it unassigned and no latch forms.
    o_available_item = '0;
    coin_sum         = '0;
    vend_hit         = 1'b0;
    vend_oh          = '0;
    vend_price       = '0;
    ret_hit          = 1'b0;
    ret_oh           = '0;
    ret_val          = '0;

    for (int i = 0; i < NUM_COINS; i++) begin
      if (i_input_coin[i]) coin_sum = coin_sum + SUM_W'(coin_val(i));
    end

    for (int i = 0; i < NUM_ITEMS; i++) begin
      o_available_item[i] = (state_q != ST_RETURN) && (credit_q >= item_price(i));
    end

    // Lowest affordable selected index wins; the rest of the request is dropped.
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (!vend_hit && i_select_item[i] && o_available_item[i]) begin
        vend_hit   = 1'b1;
        vend_oh[i] = 1'b1;
        vend_price = item_price(i);
      end
    end

    // Ascending scan; the last coin that fits is the largest one.
    for (int j = 0; j < NUM_COINS; j++) begin
      if (coin_val(j) <= credit_q) begin
        ret_hit   = 1'b1;
        ret_oh    = '0;
        ret_oh[j] = 1'b1;
        ret_val   = coin_val(j);
      end
    end
  end

  // Ceiling check covers the vend taken in the same cycle.
  always_comb begin
    after_vend  = credit_q - vend_price;
    credit_ext  = SUM_W'(after_vend) + coin_sum;
    coin_ok     = credit_ext <= SUM_W'(MAX_CREDIT);
    coin_acc    = coin_ok && (|i_input_coin);
    credit_next = coin_ok ? credit_ext[TOTAL_BITS-1:0] : after_vend;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    timer_d  = timer_q;
    item_d   = '0;
    ret_d    = '0;
    reject_d = 1'b0;

    case (state_q)
      ST_RETURN: begin
        if (ret_hit) begin
          ret_d    = ret_oh;
          credit_d = credit_q - ret_val;
        end else begin
          // Anything below the smallest coin is forfeited.
          credit_d = '0;
          state_d  = ST_IDLE;
          timer_d  = WAIT_RELOAD;
        end
      end

      default: begin
        if (state_q == ST_CREDIT && i_trigger_return) begin
          // Return request beats any coin or selection in the same cycle.
          state_d = ST_RETURN;
        end else begin
          credit_d = credit_next;
          reject_d = (|i_input_coin) && !coin_ok;
          if (vend_hit) item_d = vend_oh;

          if (coin_acc || vend_hit) begin
            timer_d = WAIT_RELOAD;
          end else if (state_q == ST_CREDIT && timer_q != 32'd0) begin
            timer_d = timer_q - 32'd1;
          end

          if (state_q == ST_CREDIT && !coin_acc && !vend_hit && timer_q == 32'd1) begin
            state_d = ST_RETURN;
          end else begin
            state_d = (credit_next != '0) ? ST_CREDIT : ST_IDLE;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      timer_q  <= WAIT_RELOAD;
      item_q   <= '0;
      ret_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      timer_q  <= timer_d;
      item_q   <= item_d;
      ret_q    <= ret_d;
      reject_q <= reject_d;
    end
  end

  assign o_output_item = item_q;
  assign o_return_coin = ret_q;
  assign o_coin_reject = reject_q;
  assign o_credit      = credit_q;
  assign o_wait_time   = timer_q;
  assign o_returning   = (state_q == ST_RETURN);

endmodule
